// File: rtl/cache_mem_block_buffer_pkg.sv
// Shared constants for the cache-to-external-memory block buffer.
// Holds the FSM state encoding and the default address, block and length widths.
package cache_mem_block_buffer_pkg;

    localparam int DEF_BW_ADDR  = 26;
    localparam int DEF_BW_BLOCK = 4;
    localparam int BW_DATA      = 32;
    localparam int BW_LEN       = DEF_BW_BLOCK + 1;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WR_COLLECT = 3'd1;
    localparam logic [2:0] ST_WR_CMD     = 3'd2;
    localparam logic [2:0] ST_WR_DATA    = 3'd3;
    localparam logic [2:0] ST_RD_CMD     = 3'd4;
    localparam logic [2:0] ST_RD_FILL    = 3'd5;

endpackage

// File: rtl/cache_mem_block_buffer_if.sv
// Cache-side command/data strobes and external-memory burst interface.
// The slave modport is the buffer's view; master is the cache plus memory side.
interface cache_mem_block_buffer_if
    import cache_mem_block_buffer_pkg::*;
#(
    parameter int BW_ADDR  = DEF_BW_ADDR,
    parameter int BW_BLOCK = DEF_BW_BLOCK
);
    // cache controller side
    logic                  req_i;
    logic                  req_block_i;
    logic                  rw_i;
    logic [BW_ADDR-1:0]    add_i;
    logic                  write_i;
    logic [BW_DATA-1:0]    data_i;
    logic                  read_i;
    logic                  ready_req_o;
    logic                  ready_write_o;
    logic                  ready_read_o;
    logic [BW_DATA-1:0]    data_o;

    // external memory side
    logic                  ext_req_o;
    logic                  ext_ack_i;
    logic                  ext_rw_o;
    logic [BW_ADDR-1:0]    ext_add_o;
    logic [BW_BLOCK:0]     ext_len_o;
    logic                  ext_wvalid_o;
    logic [BW_DATA-1:0]    ext_wdata_o;
    logic                  ext_wready_i;
    logic                  ext_rvalid_i;
    logic [BW_DATA-1:0]    ext_rdata_i;

    modport slave (
        input  req_i, req_block_i, rw_i, add_i, write_i, data_i, read_i,
        output ready_req_o, ready_write_o, ready_read_o, data_o,
        output ext_req_o, ext_rw_o, ext_add_o, ext_len_o, ext_wvalid_o, ext_wdata_o,
        input  ext_ack_i, ext_wready_i, ext_rvalid_i, ext_rdata_i
    );

    modport master (
        output req_i, req_block_i, rw_i, add_i, write_i, data_i, read_i,
        input  ready_req_o, ready_write_o, ready_read_o, data_o,
        input  ext_req_o, ext_rw_o, ext_add_o, ext_len_o, ext_wvalid_o, ext_wdata_o,
        output ext_ack_i, ext_wready_i, ext_rvalid_i, ext_rdata_i
    );

endinterface

// File: rtl/cache_mem_block_buffer_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
// dout reads as zero while empty so downstream buses idle at a known value.
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by count_q, so resetting it would only cost area.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/cache_mem_block_buffer.sv
// Buffers one cache read/write command (single word or whole block) and
// replays it as a single burst on the external memory command/data interface.
module cache_mem_block_buffer
    import cache_mem_block_buffer_pkg::*;
#(
    parameter int BW_ADDR     = DEF_BW_ADDR,
    parameter int BW_BLOCK    = DEF_BW_BLOCK,
    parameter int BLOCK_WORDS = 2 ** DEF_BW_BLOCK
) (
    input  logic                      clock_i,
    input  logic                      resetn_i,
    cache_mem_block_buffer_if.slave   bus,
    output logic                      busy_o,
    output logic                      err_o
);
    localparam int LEN_W = BW_BLOCK + 1;

    typedef logic [LEN_W-1:0] len_t;

    typedef struct packed {
        logic               rw;
        len_t               len;
        logic [BW_ADDR-1:0] addr;
    } cmd_t;

    logic [2:0]         state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    len_t               in_cnt_q, in_cnt_d;
    len_t               out_cnt_q, out_cnt_d;
    logic               err_q, err_d;

    logic               fifo_push, fifo_pop;
    logic [BW_DATA-1:0] fifo_din, fifo_dout;
    logic               fifo_empty, fifo_full;

    logic               in_idle, ready_write, ready_read, rd_room;
    logic               wr_push, rd_push, wr_pop, rd_pop, wvalid;

    // Handshake qualifiers; the in-count limit stops pushes once N words are held.
    assign in_idle     = (state_q == ST_IDLE);
    assign ready_write = (state_q == ST_WR_COLLECT) && (in_cnt_q < cmd_q.len) && !fifo_full;
    assign rd_room     = (state_q == ST_RD_FILL) && (in_cnt_q < cmd_q.len) && !fifo_full;
    assign ready_read  = (state_q == ST_RD_FILL) && !fifo_empty;
    assign wvalid      = (state_q == ST_WR_DATA) && !fifo_empty;

    assign wr_push   = bus.write_i & ready_write;
    assign rd_push   = bus.ext_rvalid_i & rd_room;
    assign wr_pop    = wvalid & bus.ext_wready_i;
    assign rd_pop    = bus.read_i & ready_read;
    assign fifo_push = wr_push | rd_push;
    assign fifo_pop  = wr_pop | rd_pop;
    assign fifo_din  = (state_q == ST_RD_FILL) ? bus.ext_rdata_i : bus.data_i;

    // Reads and writes never overlap, so one FIFO serves both directions.
    sync_fifo_fwft #(
        .DEPTH (BLOCK_WORDS),
        .WIDTH (BW_DATA)
    ) u_fifo (
        .clk   (clock_i),
        .rst_n (resetn_i),
        .flush (~resetn_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        in_cnt_d  = in_cnt_q + {{(LEN_W-1){1'b0}}, fifo_push};
        out_cnt_d = out_cnt_q + {{(LEN_W-1){1'b0}}, fifo_pop};
        err_d     = err_q
                  | (bus.write_i & ~ready_write)
                  | (bus.read_i & ~ready_read)
                  | (bus.ext_rvalid_i & ~rd_room);

        case (state_q)
            ST_IDLE: begin
                if (bus.req_i) begin
                    cmd_d.rw   = bus.rw_i;
                    cmd_d.len  = bus.req_block_i ? len_t'(BLOCK_WORDS) : len_t'(1);
                    cmd_d.addr = bus.req_block_i
                               ? {bus.add_i[BW_ADDR-1:BW_BLOCK], {BW_BLOCK{1'b0}}}
                               : bus.add_i;
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    state_d    = bus.rw_i ? ST_WR_COLLECT : ST_RD_CMD;
                end
            end
            // Registered count check gives one idle cycle after the last word.
            ST_WR_COLLECT: if (in_cnt_q == cmd_q.len) state_d = ST_WR_CMD;
            ST_WR_CMD:     if (bus.ext_ack_i) state_d = ST_WR_DATA;
            ST_WR_DATA:    if (out_cnt_d == cmd_q.len) state_d = ST_IDLE;
            ST_RD_CMD:     if (bus.ext_ack_i) state_d = ST_RD_FILL;
            ST_RD_FILL: begin
                if ((in_cnt_d == cmd_q.len) && (out_cnt_d == cmd_q.len)) state_d = ST_IDLE;
            end
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.ready_req_o   = in_idle;
    assign bus.ready_write_o = ready_write;
    assign bus.ready_read_o  = ready_read;
    assign bus.data_o        = fifo_dout;
    assign bus.ext_req_o     = (state_q == ST_WR_CMD) || (state_q == ST_RD_CMD);
    assign bus.ext_rw_o      = cmd_q.rw;
    assign bus.ext_add_o     = cmd_q.addr;
    assign bus.ext_len_o     = cmd_q.len;
    assign bus.ext_wvalid_o  = wvalid;
    assign bus.ext_wdata_o   = fifo_dout;
    assign busy_o            = !in_idle;
    assign err_o             = err_q;

endmodule

// File: tb/tb_cache_mem_block_buffer.sv
// Directed bench for cache_mem_block_buffer: block/single transfers,
// backpressure, protocol errors and reset in the middle of a fill.
module tb_cache_mem_block_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, err;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cache_mem_block_buffer_if bus ();

    cache_mem_block_buffer dut (
        .clock_i  (clk),
        .resetn_i (rst_n),
        .bus      (bus),
        .busy_o   (busy),
        .err_o    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic issue(input logic rw, input logic blk, input logic [25:0] a);
        bus.req_i       = 1'b1;
        bus.rw_i        = rw;
        bus.req_block_i = blk;
        bus.add_i       = a;
        step();
        bus.req_i       = 1'b0;
        bus.rw_i        = 1'b0;
        bus.req_block_i = 1'b0;
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            bus.write_i = 1'b1;
            bus.data_i  = base + 32'(i);
            step();
        end
        bus.write_i = 1'b0;
    endtask

    task automatic ack();
        bus.ext_ack_i = 1'b1;
        step();
        bus.ext_ack_i = 1'b0;
    endtask

    // bp selects the wready pattern 1,0,0,1 instead of constant 1.
    task automatic drain_write(input string tag, input logic [31:0] base, input int n, input bit bp);
        int beats = 0;
        for (int c = 0; c < 200 && beats < n; c++) begin
            bus.ext_wready_i = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            if (bus.ext_wvalid_o) begin
                check(bus.ext_wready_i ? tag : {tag, "_hold"}, bus.ext_wdata_o, base + 32'(beats));
                if (bus.ext_wready_i) beats++;
            end
            step();
        end
        bus.ext_wready_i = 1'b0;
        check({tag, "_beats"}, 32'(beats), 32'(n));
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_ready_req"}, {31'd0, bus.ready_req_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent, got;
        bus.req_i = 0; bus.req_block_i = 0; bus.rw_i = 0; bus.add_i = '0;
        bus.write_i = 0; bus.data_i = '0; bus.read_i = 0;
        bus.ext_ack_i = 0; bus.ext_wready_i = 0; bus.ext_rvalid_i = 0; bus.ext_rdata_i = '0;

        // reset state
        step();
        check("rst_ready_req", {31'd0, bus.ready_req_o}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_data_o", bus.data_o, 32'd0);
        check("rst_ext_add", 32'(bus.ext_add_o), 32'd0);
        check("rst_ext_req", {31'd0, bus.ext_req_o}, 32'd0);
        check("rst_ready_wr", {31'd0, bus.ready_write_o}, 32'd0);
        rst_n = 1'b1;
        step();

        // block write, ack on the third command cycle
        issue(1'b1, 1'b1, 26'h000123);
        check("bw_busy", {31'd0, busy}, 32'd1);
        check("bw_ready_req", {31'd0, bus.ready_req_o}, 32'd0);
        check("bw_ready_wr", {31'd0, bus.ready_write_o}, 32'd1);
        push_words(16, 32'd0);
        check("bw_full_ready_wr", {31'd0, bus.ready_write_o}, 32'd0);
        step();
        check("bw_ext_req", {31'd0, bus.ext_req_o}, 32'd1);
        check("bw_ext_add", 32'(bus.ext_add_o), 32'h120);
        check("bw_ext_len", 32'(bus.ext_len_o), 32'd16);
        check("bw_ext_rw", {31'd0, bus.ext_rw_o}, 32'd1);
        step();
        step();
        check("bw_ext_req_held", {31'd0, bus.ext_req_o}, 32'd1);
        check("bw_ext_add_held", 32'(bus.ext_add_o), 32'h120);
        ack();
        drain_write("bw_word", 32'd0, 16, 1'b0);

        // block read with drain overlapping the fill
        issue(1'b0, 1'b1, 26'h000040);
        check("br_ext_req", {31'd0, bus.ext_req_o}, 32'd1);
        check("br_ext_rw", {31'd0, bus.ext_rw_o}, 32'd0);
        check("br_ext_add", 32'(bus.ext_add_o), 32'h40);
        check("br_ext_len", 32'(bus.ext_len_o), 32'd16);
        ack();
        sent = 0;
        got = 0;
        for (int c = 0; c < 100 && got < 16; c++) begin
            bus.ext_rvalid_i = (c % 2 == 0) && (sent < 16);
            bus.ext_rdata_i  = 32'hA0 + 32'(sent);
            bus.read_i       = bus.ready_read_o;
            if (bus.read_i) begin
                check("br_word", bus.data_o, 32'hA0 + 32'(got));
                got++;
            end
            if (bus.ext_rvalid_i) sent++;
            step();
        end
        bus.ext_rvalid_i = 0;
        bus.read_i = 0;
        check("br_count", 32'(got), 32'd16);
        check("br_idle", {31'd0, busy}, 32'd0);
        check("br_ready_req", {31'd0, bus.ready_req_o}, 32'd1);
        check("br_err", {31'd0, err}, 32'd0);

        // single-word read
        issue(1'b0, 1'b0, 26'h000007);
        check("sr_ext_add", 32'(bus.ext_add_o), 32'h7);
        check("sr_ext_len", 32'(bus.ext_len_o), 32'd1);
        ack();
        bus.ext_rvalid_i = 1;
        bus.ext_rdata_i  = 32'h55;
        step();
        bus.ext_rvalid_i = 0;
        check("sr_ready_rd", {31'd0, bus.ready_read_o}, 32'd1);
        check("sr_data", bus.data_o, 32'h55);
        bus.read_i = 1;
        step();
        bus.read_i = 0;
        check("sr_idle", {31'd0, busy}, 32'd0);
        check("sr_err_clean", {31'd0, err}, 32'd0);
        bus.ext_rvalid_i = 1;
        bus.ext_rdata_i  = 32'h66;
        step();
        bus.ext_rvalid_i = 0;
        check("sr_extra_err", {31'd0, err}, 32'd1);
        check("sr_extra_ready_rd", {31'd0, bus.ready_read_o}, 32'd0);
        check("sr_extra_data", bus.data_o, 32'd0);
        do_reset();
        check("sr_err_cleared", {31'd0, err}, 32'd0);

        // block write under external backpressure
        issue(1'b1, 1'b1, 26'h000205);
        push_words(16, 32'h100);
        step();
        check("bp_ext_add", 32'(bus.ext_add_o), 32'h200);
        ack();
        drain_write("bp_word", 32'h100, 16, 1'b1);

        // protocol errors: stray write in IDLE, stray rvalid in WR_CMD
        bus.write_i = 1;
        bus.data_i  = 32'hDEAD;
        step();
        bus.write_i = 0;
        check("pe_wr_idle_err", {31'd0, err}, 32'd1);
        check("pe_wr_idle_busy", {31'd0, busy}, 32'd0);
        issue(1'b1, 1'b1, 26'h000300);
        push_words(16, 32'h300);
        step();
        check("pe_ext_req", {31'd0, bus.ext_req_o}, 32'd1);
        bus.ext_rvalid_i = 1;
        bus.ext_rdata_i  = 32'hBAD;
        step();
        bus.ext_rvalid_i = 0;
        check("pe_rv_err", {31'd0, err}, 32'd1);
        check("pe_ext_req_held", {31'd0, bus.ext_req_o}, 32'd1);
        ack();
        drain_write("pe_word", 32'h300, 16, 1'b0);
        check("pe_err_sticky", {31'd0, err}, 32'd1);

        // reset in the middle of a fill, rvalid every cycle (push and pop overlap)
        issue(1'b0, 1'b1, 26'h000080);
        ack();
        sent = 0;
        got = 0;
        for (int c = 0; c < 5; c++) begin
            bus.ext_rvalid_i = 1;
            bus.ext_rdata_i  = 32'hC0 + 32'(sent);
            bus.read_i       = bus.ready_read_o;
            if (bus.read_i) begin
                check("rm_word", bus.data_o, 32'hC0 + 32'(got));
                got++;
            end
            sent++;
            step();
        end
        bus.ext_rvalid_i = 0;
        bus.read_i = 0;
        check("rm_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #2;
        check("rm_ready_req", {31'd0, bus.ready_req_o}, 32'd1);
        check("rm_ready_rd", {31'd0, bus.ready_read_o}, 32'd0);
        check("rm_busy", {31'd0, busy}, 32'd0);
        check("rm_err", {31'd0, err}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // fresh single-word write after the reset
        issue(1'b1, 1'b0, 26'h000015);
        push_words(1, 32'hBEEF);
        step();
        check("nw_ext_add", 32'(bus.ext_add_o), 32'h15);
        check("nw_ext_len", 32'(bus.ext_len_o), 32'd1);
        check("nw_ext_rw", {31'd0, bus.ext_rw_o}, 32'd1);
        ack();
        drain_write("nw_word", 32'hBEEF, 1, 1'b0);
        check("nw_err", {31'd0, err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
